// File: rtl/cpu_loader_if.sv
// Stream and external-memory bundle between cpu_loader and its host/CPU surroundings.
// The master side is the loader; the slave side is the host stream source/sink and the memories.
interface cpu_loader_if;
    logic        s_valid;
    logic        s_ready;
    logic [31:0] s_data;
    logic        m_valid;
    logic        m_ready;
    logic [31:0] m_data;
    logic [31:0] addr_ext;
    logic        wen_ext;
    logic        ren_ext;
    logic [31:0] wdata_ext;
    logic [31:0] addr_ext_2;
    logic        wen_ext_2;
    logic        ren_ext_2;
    logic [31:0] wdata_ext_2;
    logic [31:0] rdata_ext_2;

    modport master (
        input  s_valid, s_data, m_ready, rdata_ext_2,
        output s_ready, m_valid, m_data,
        output addr_ext, wen_ext, ren_ext, wdata_ext,
        output addr_ext_2, wen_ext_2, ren_ext_2, wdata_ext_2
    );

    modport slave (
        output s_valid, s_data, m_ready, rdata_ext_2,
        input  s_ready, m_valid, m_data,
        input  addr_ext, wen_ext, ren_ext, wdata_ext,
        input  addr_ext_2, wen_ext_2, ren_ext_2, wdata_ext_2
    );
endinterface

// File: rtl/cpu_loader.sv
// Host-side sequencer: streams IMEM/DMEM images in, runs the CPU for a set number of
// cycles, then reads a window of DMEM back out on the dump stream.
module cpu_loader #(
    parameter int ADDR_STEP = 4,
    parameter int CNT_W     = 16
) (
    input  logic             clk,
    input  logic             arst,
    input  logic             start,
    input  logic [CNT_W-1:0] imem_words,
    input  logic [CNT_W-1:0] dmem_words,
    input  logic [31:0]      run_cycles,
    input  logic [CNT_W-1:0] dump_words,
    cpu_loader_if.master     bus,
    output logic             cpu_enable,
    output logic             busy,
    output logic             done
);
    typedef enum logic [2:0] {IDLE, LOAD_I, LOAD_D, RUN, RD_REQ, RD_WAIT, DONE} state_t;

    state_t           state, state_nxt;
    logic [CNT_W-1:0] idx, idx_nxt;
    logic [CNT_W-1:0] n_i, n_d, n_dump;
    logic             run_nz;
    logic [31:0]      run_cnt;
    logic             ld_fin, fin_nxt;
    logic             s_hs, m_hs;

    function automatic state_t after_load(input logic rnz, input logic dnz);
        if (rnz)      return RUN;
        else if (dnz) return RD_REQ;
        else          return DONE;
    endfunction

    function automatic logic [31:0] word_addr(input logic [CNT_W-1:0] i);
        return 32'(i) * 32'(ADDR_STEP);
    endfunction

    // ld_fin marks the drain cycle after the final load handshake, while its write pulse is out
    assign bus.s_ready = (state == LOAD_I || state == LOAD_D) && !ld_fin;
    assign bus.ren_ext = 1'b0;
    assign s_hs        = bus.s_valid & bus.s_ready;
    assign m_hs        = bus.m_valid & bus.m_ready;

    always_comb begin
        state_nxt = state;
        idx_nxt   = idx;
        fin_nxt   = ld_fin;
        case (state)
            IDLE, DONE: if (start) begin
                idx_nxt = '0;
                fin_nxt = 1'b0;
                if (imem_words != '0)      state_nxt = LOAD_I;
                else if (dmem_words != '0) state_nxt = LOAD_D;
                else                       state_nxt = after_load(run_cycles != '0, dump_words != '0);
            end
            LOAD_I: begin
                if (ld_fin) begin
                    fin_nxt   = 1'b0;
                    state_nxt = after_load(run_nz, n_dump != '0);
                end else if (s_hs) begin
                    if (idx == n_i - CNT_W'(1)) begin
                        idx_nxt = '0;
                        if (n_d != '0) state_nxt = LOAD_D;
                        else           fin_nxt   = 1'b1;
                    end else begin
                        idx_nxt = idx + CNT_W'(1);
                    end
                end
            end
            LOAD_D: begin
                if (ld_fin) begin
                    fin_nxt   = 1'b0;
                    state_nxt = after_load(run_nz, n_dump != '0);
                end else if (s_hs) begin
                    if (idx == n_d - CNT_W'(1)) begin
                        idx_nxt = '0;
                        fin_nxt = 1'b1;
                    end else begin
                        idx_nxt = idx + CNT_W'(1);
                    end
                end
            end
            RUN:     if (run_cnt == '0) state_nxt = (n_dump != '0) ? RD_REQ : DONE;
            RD_REQ:  state_nxt = RD_WAIT;
            RD_WAIT: if (m_hs) begin
                if (idx == n_dump - CNT_W'(1)) begin
                    state_nxt = DONE;
                end else begin
                    idx_nxt   = idx + CNT_W'(1);
                    state_nxt = RD_REQ;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            state           <= IDLE;
            idx             <= '0;
            ld_fin          <= 1'b0;
            n_i             <= '0;
            n_d             <= '0;
            n_dump          <= '0;
            run_nz          <= 1'b0;
            run_cnt         <= '0;
            bus.wen_ext     <= 1'b0;
            bus.addr_ext    <= '0;
            bus.wdata_ext   <= '0;
            bus.wen_ext_2   <= 1'b0;
            bus.ren_ext_2   <= 1'b0;
            bus.addr_ext_2  <= '0;
            bus.wdata_ext_2 <= '0;
            bus.m_valid     <= 1'b0;
            bus.m_data      <= '0;
            cpu_enable      <= 1'b0;
            busy            <= 1'b0;
            done            <= 1'b0;
        end else begin
            state  <= state_nxt;
            idx    <= idx_nxt;
            ld_fin <= fin_nxt;
            if ((state == IDLE || state == DONE) && start) begin
                n_i     <= imem_words;
                n_d     <= dmem_words;
                n_dump  <= dump_words;
                run_nz  <= run_cycles != '0;
                run_cnt <= run_cycles - 32'd1;
            end else if (state == RUN && run_cnt != '0) begin
                run_cnt <= run_cnt - 32'd1;
            end

            bus.wen_ext <= (state == LOAD_I) && s_hs;
            if (state == LOAD_I && s_hs) begin
                bus.addr_ext  <= word_addr(idx);
                bus.wdata_ext <= bus.s_data;
            end

            bus.wen_ext_2 <= (state == LOAD_D) && s_hs;
            bus.ren_ext_2 <= (state_nxt == RD_REQ);
            if (state == LOAD_D && s_hs) begin
                bus.addr_ext_2  <= word_addr(idx);
                bus.wdata_ext_2 <= bus.s_data;
            end else if (state_nxt == RD_REQ) begin
                bus.addr_ext_2  <= word_addr(idx_nxt);
            end

            // read data lands the cycle after RD_REQ, i.e. the first RD_WAIT cycle
            if (state == RD_WAIT) begin
                if (!bus.m_valid) begin
                    bus.m_valid <= 1'b1;
                    bus.m_data  <= bus.rdata_ext_2;
                end else if (bus.m_ready) begin
                    bus.m_valid <= 1'b0;
                end
            end

            cpu_enable <= (state_nxt == RUN);
            busy       <= !(state_nxt == IDLE || state_nxt == DONE);
            done       <= (state_nxt == DONE);
        end
    end
endmodule

// File: tb/tb_cpu_loader.sv
// Bench for cpu_loader: directed scenarios plus randomized flows, with a DMEM model and
// expectations built from the stream contents and counts.
module tb_cpu_loader;
    localparam int CNT_W = 16;

    logic             clk = 1'b0;
    logic             arst;
    logic             start;
    logic [CNT_W-1:0] imem_words, dmem_words, dump_words;
    logic [31:0]      run_cycles;
    logic             cpu_enable, busy, done;

    cpu_loader_if bus();

    cpu_loader #(.ADDR_STEP(4), .CNT_W(CNT_W)) dut (
        .clk(clk), .arst(arst), .start(start),
        .imem_words(imem_words), .dmem_words(dmem_words),
        .run_cycles(run_cycles), .dump_words(dump_words),
        .bus(bus),
        .cpu_enable(cpu_enable), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    logic [31:0] dmem [0:255];
    always @(posedge clk) begin
        if (bus.wen_ext_2) dmem[bus.addr_ext_2[9:2]] <= bus.wdata_ext_2;
        if (bus.ren_ext_2) bus.rdata_ext_2 <= dmem[bus.addr_ext_2[9:2]];
    end

    int checks = 0;
    int errors = 0;
    logic [31:0] stim[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // vmode: 0 valid held, 1 toggling, 2 random; rmode: 0 ready held, 1 low for 10 cycles, 2 random
    task automatic flow(input int ni, input int nd, input int nr, input int nw,
                        input int vmode, input int rmode, input int rst_at, input int bs);
        int p = 0, en_cnt = 0, en_first = -1, en_last = -1, done_cyc = -1, mv_first = -1;
        int viol = 0, hold = 0, bs_done = 0, busy1 = -1;
        logic prev_mv = 1'b0, prev_mr = 1'b0;
        logic [31:0] prev_md = '0;
        logic [31:0] iwa[$], iwd[$], dwa[$], dwd[$], rda[$], dmp[$];
        int iwc[$], dwc[$], rdc[$], dmc[$];
        bit reset_hit = 0;

        imem_words = CNT_W'(ni); dmem_words = CNT_W'(nd);
        run_cycles = 32'(nr);    dump_words = CNT_W'(nw);
        for (int cyc = 0; cyc < 3000; cyc++) begin
            @(posedge clk); #1;
            if (bus.wen_ext)   begin iwa.push_back(bus.addr_ext);   iwd.push_back(bus.wdata_ext);   iwc.push_back(cyc); end
            if (bus.wen_ext_2) begin dwa.push_back(bus.addr_ext_2); dwd.push_back(bus.wdata_ext_2); dwc.push_back(cyc); end
            if (bus.ren_ext_2) begin rda.push_back(bus.addr_ext_2); rdc.push_back(cyc); if (bus.m_valid) viol++; end
            if (cpu_enable) begin if (en_first < 0) en_first = cyc; en_last = cyc; en_cnt++; end
            if (bus.m_valid && mv_first < 0) mv_first = cyc;
            if (prev_mv && !prev_mr && (!bus.m_valid || bus.m_data !== prev_md)) viol++;
            if (cyc == 1) busy1 = int'(busy);
            if (cyc > 0 && done) begin done_cyc = cyc; break; end
            if (rst_at > 0 && en_cnt == rst_at) begin
                arst = 1'b1; #1;
                chk("rst_async_cpu_enable", 32'(cpu_enable), 0);
                chk("rst_async_busy", 32'(busy), 0);
                chk("rst_async_done", 32'(done), 0);
                #2 arst = 1'b0;
                reset_hit = 1;
                break;
            end
            start = (cyc == 0);
            if (bs != 0 && bs_done == 0 && dwc.size() == 1) begin
                start = 1'b1; imem_words = CNT_W'(ni + 3); dmem_words = 1;
                run_cycles = 1; dump_words = 0; bs_done = 1;
            end
            bus.s_valid = (p < ni + nd) && (vmode == 0 || (vmode == 1 && cyc % 2 == 1) ||
                                            (vmode == 2 && $urandom_range(1, 0) == 1));
            bus.s_data  = (p < ni + nd) ? stim[p] : 32'h0;
            if (bus.m_valid) hold++;
            bus.m_ready = (rmode == 0) ? 1'b1 : (rmode == 1) ? (hold > 10) : ($urandom_range(3, 0) == 0);
            if (bus.s_valid && bus.s_ready) p++;
            if (bus.m_valid && bus.m_ready) begin dmp.push_back(bus.m_data); dmc.push_back(cyc); end
            prev_mv = bus.m_valid; prev_mr = bus.m_ready; prev_md = bus.m_data;
        end
        start = 1'b0; bus.s_valid = 1'b0; bus.m_ready = 1'b0;

        if (rst_at > 0) begin
            chk("rst_reached", 32'(reset_hit), 1);
            @(negedge clk);
            chk("rst_idle_m_valid", 32'(bus.m_valid), 0);
            chk("rst_idle_s_ready", 32'(bus.s_ready), 0);
            chk("rst_idle_cpu_enable", 32'(cpu_enable), 0);
            return;
        end

        chk("done_reached", 32'(done_cyc > 0), 1);
        if (ni + nd + nr + nw > 0) chk("busy_after_start", 32'(busy1), 1);
        chk("imem_wr_count", iwa.size(), ni);
        for (int i = 0; i < iwa.size() && i < ni; i++) begin
            chk("imem_wr_addr", iwa[i], 32'(i * 4));
            chk("imem_wr_data", iwd[i], stim[i]);
            if (vmode == 0 && i > 0) chk("imem_wr_b2b", iwc[i] - iwc[i-1], 1);
        end
        if (vmode == 0 && ni > 0) chk("imem_wr_latency", iwc[0], 2);
        chk("dmem_wr_count", dwa.size(), nd);
        for (int i = 0; i < dwa.size() && i < nd; i++) begin
            chk("dmem_wr_addr", dwa[i], 32'(i * 4));
            chk("dmem_wr_data", dwd[i], stim[ni + i]);
            if (vmode == 0 && i > 0) chk("dmem_wr_b2b", dwc[i] - dwc[i-1], 1);
        end
        if (vmode == 0 && ni > 0 && nd > 0 && iwc.size() == ni && dwc.size() > 0)
            chk("load_i_to_d_no_bubble", dwc[0] - iwc[ni-1], 1);
        chk("cpu_enable_cycles", en_cnt, nr);
        if (nr > 0) begin
            chk("cpu_enable_contiguous", en_last - en_first + 1, nr);
            if (nd > 0 && dwc.size() > 0) chk("run_entry_after_dmem", en_first - dwc[dwc.size()-1], 1);
            else if (ni == 0)             chk("run_entry_after_start", en_first, 1);
        end
        chk("dump_read_count", rda.size(), nw);
        for (int i = 0; i < rda.size() && i < nw; i++) chk("dump_read_addr", rda[i], 32'(i * 4));
        if (nw > 0 && rdc.size() > 0) chk("m_valid_rise", mv_first - rdc[0], 2);
        chk("dump_word_count", dmp.size(), nw);
        for (int i = 0; i < dmp.size() && i < nw; i++) chk("dump_data", dmp[i], stim[ni + i]);
        chk("dump_hold_violations", viol, 0);
        if (nw > 0 && dmc.size() > 0) chk("done_after_dump", done_cyc - dmc[dmc.size()-1], 1);
        else if (nw == 0 && nr > 0)   chk("done_after_run", done_cyc - en_last, 1);
        else if (ni + nd + nr + nw == 0) chk("done_after_start", done_cyc, 1);
    endtask

    task automatic fill_rand(input int n);
        stim.delete();
        for (int i = 0; i < n; i++) stim.push_back($urandom);
    endtask

    initial begin
        arst = 1'b1; start = 1'b0;
        imem_words = '0; dmem_words = '0; run_cycles = '0; dump_words = '0;
        bus.s_valid = 1'b0; bus.s_data = '0; bus.m_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_cpu_enable", 32'(cpu_enable), 0);
        chk("reset_busy", 32'(busy), 0);
        chk("reset_done", 32'(done), 0);
        chk("reset_s_ready", 32'(bus.s_ready), 0);
        chk("reset_m_valid", 32'(bus.m_valid), 0);
        chk("reset_m_data", bus.m_data, 0);
        chk("reset_wen_ext", 32'(bus.wen_ext), 0);
        chk("reset_ren_ext", 32'(bus.ren_ext), 0);
        chk("reset_addr_ext", bus.addr_ext, 0);
        chk("reset_wdata_ext", bus.wdata_ext, 0);
        chk("reset_wen_ext_2", 32'(bus.wen_ext_2), 0);
        chk("reset_ren_ext_2", 32'(bus.ren_ext_2), 0);
        chk("reset_addr_ext_2", bus.addr_ext_2, 0);
        chk("reset_wdata_ext_2", bus.wdata_ext_2, 0);
        arst = 1'b0;

        // full flow with the reference image
        stim.delete();
        for (int i = 0; i < 5; i++) stim.push_back(32'hA0 + 32'(i));
        flow(3, 2, 5, 2, 0, 0, 0, 0);

        // stream stalls on a 4-word IMEM load
        fill_rand(5);
        flow(4, 1, 2, 1, 1, 0, 0, 0);

        // dump backpressure
        fill_rand(3);
        flow(1, 2, 3, 2, 0, 1, 0, 0);

        // all counts zero
        flow(0, 0, 0, 0, 0, 0, 0, 0);

        // reset on the 3rd cycle of a long run, then a clean restart
        fill_rand(3);
        flow(2, 1, 100, 1, 0, 0, 3, 0);
        fill_rand(4);
        flow(3, 1, 2, 1, 0, 0, 0, 0);

        // start pulsed during LOAD_D with different counts
        fill_rand(6);
        flow(2, 4, 3, 2, 0, 0, 0, 1);

        // run-only and dump-only corner flows
        flow(0, 0, 4, 0, 0, 0, 0, 0);
        fill_rand(2);
        flow(0, 2, 0, 2, 0, 0, 0, 0);

        // randomized flows
        for (int t = 0; t < 20; t++) begin
            int ni, nd, nr, nw;
            ni = $urandom_range(6, 0);
            nd = $urandom_range(6, 0);
            nr = $urandom_range(8, 0);
            nw = $urandom_range(nd, 0);
            fill_rand(ni + nd);
            flow(ni, nd, nr, nw, 2, 2, 0, 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
